// File: rtl/wb_pkg.sv
// Shared Wishbone widths and responder FSM state encoding.
package wb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_ram_array.sv
// Single-port word RAM: synchronous read, per-byte write enables.
module wb_ram_array
    import wb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WB_SEL_W-1:0]   be,
    input  logic [WB_DAT_W-1:0]   wdata,
    output logic [WB_DAT_W-1:0]   rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WB_DAT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WB_SEL_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic RAM responder with WAIT_STATES extra cycles before ack.
// Define WB_ERR_EN to add bus__err for addresses beyond the RAM depth.
module wb_ram_responder
    import wb_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bus__cyc,
    input  logic                bus__stb,
    input  logic                bus__we,
    input  logic [WB_ADR_W-1:0] bus__adr,
    input  logic [WB_SEL_W-1:0] bus__sel,
    input  logic [WB_DAT_W-1:0] bus__dat_w,
    output logic [WB_DAT_W-1:0] bus__dat_r,
    output logic                bus__ack
`ifdef WB_ERR_EN
    ,
    output logic                bus__err
`endif
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    wb_state_t             state;
    logic [2:0]            cnt;
    logic                  req;
    logic                  req_err;
    logic                  enter_ack;
    logic                  from_bus;
    logic                  sel_we;
    logic                  sel_err;
    logic [DEPTH_LOG2-1:0] sel_adr;
    logic [WB_SEL_W-1:0]   sel_be;
    logic [WB_DAT_W-1:0]   sel_dat;
    logic                  mem_en;
    logic                  mem_we;
    logic [WB_DAT_W-1:0]   rdata;

    logic [DEPTH_LOG2-1:0] adr_p1;
    logic                  we_p1;
    logic                  err_p1;
    logic [WB_SEL_W-1:0]   sel_p1;
    logic [WB_DAT_W-1:0]   dat_p1;

    logic                  err_p2;
    logic                  rd_p2;

    assign req = bus__cyc & bus__stb;

`ifdef WB_ERR_EN
    assign req_err  = |bus__adr[WB_ADR_W-1:DEPTH_LOG2];
    assign bus__err = err_p2;
`else
    // Upper address bits alias onto the RAM when out-of-range errors are off.
    logic unused_adr_hi;
    logic unused_err;
    assign req_err       = 1'b0;
    assign unused_adr_hi = ^bus__adr[WB_ADR_W-1:DEPTH_LOG2];
    assign unused_err    = err_p2;
`endif

    // With zero wait states the RAM access happens on the accepting edge, so
    // the request comes straight from the bus instead of the latched copy.
    always_comb begin
        from_bus  = (state == IDLE);
        enter_ack = 1'b0;
        if ((state == IDLE) && req && (WS == 3'd0)) begin
            enter_ack = 1'b1;
        end
        if ((state == WAIT) && bus__cyc && (cnt == 3'd1)) begin
            enter_ack = 1'b1;
        end
        sel_adr = from_bus ? bus__adr[DEPTH_LOG2-1:0] : adr_p1;
        sel_we  = from_bus ? bus__we    : we_p1;
        sel_err = from_bus ? req_err    : err_p1;
        sel_be  = from_bus ? bus__sel   : sel_p1;
        sel_dat = from_bus ? bus__dat_w : dat_p1;
        mem_en  = enter_ack & ~rst;
        mem_we  = mem_en & sel_we & ~sel_err;
    end

    // Request capture (p1): held stable for the whole transfer
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req) begin
            adr_p1 <= bus__adr[DEPTH_LOG2-1:0];
            we_p1  <= bus__we;
            err_p1 <= req_err;
            sel_p1 <= bus__sel;
            dat_p1 <= bus__dat_w;
        end
    end

    // Control FSM (p2): ack/err/read-valid registered for the ACK cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            bus__ack <= 1'b0;
            err_p2   <= 1'b0;
            rd_p2    <= 1'b0;
        end else begin
            bus__ack <= 1'b0;
            err_p2   <= 1'b0;
            rd_p2    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req && (WS != 3'd0)) begin
                        state <= WAIT;
                        cnt   <= WS;
                    end
                end
                WAIT: begin
                    if (!bus__cyc) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
            if (enter_ack) begin
                state    <= ACK;
                cnt      <= 3'd0;
                bus__ack <= ~sel_err;
                err_p2   <= sel_err;
                rd_p2    <= ~sel_we & ~sel_err;
            end
        end
    end

    assign bus__dat_r = rd_p2 ? rdata : '0;

    wb_ram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .addr (sel_adr),
        .be   (sel_be),
        .wdata(sel_dat),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_wb_ram_responder.sv
// Bench for wb_ram_responder: one instance with 0 and one with 3 wait states.
// Compile with WB_ERR_EN defined to exercise the out-of-range error path.
module tb_wb_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cyc, stb, we;
    logic [29:0] adr   [2];
    logic [3:0]  sel   [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r0, dat_r3;
    logic        ack0, ack3, err0, err3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory for the random test region (0x100..0x10F), per DUT.
    logic [31:0] mdl [2][16];

    always #5 clk = ~clk;

    wb_ram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus__cyc(cyc[0]), .bus__stb(stb[0]), .bus__we(we[0]),
        .bus__adr(adr[0]), .bus__sel(sel[0]), .bus__dat_w(dat_w[0]),
        .bus__dat_r(dat_r0), .bus__ack(ack0)
`ifdef WB_ERR_EN
        , .bus__err(err0)
`endif
    );

    wb_ram_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .bus__cyc(cyc[1]), .bus__stb(stb[1]), .bus__we(we[1]),
        .bus__adr(adr[1]), .bus__sel(sel[1]), .bus__dat_w(dat_w[1]),
        .bus__dat_r(dat_r3), .bus__ack(ack3)
`ifdef WB_ERR_EN
        , .bus__err(err3)
`endif
    );

`ifndef WB_ERR_EN
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    task automatic sample(input int d, output logic a, output logic e, output logic [31:0] r);
        if (d == 0) begin a = ack0; e = err0; r = dat_r0; end
        else        begin a = ack3; e = err3; r = dat_r3; end
    endtask

    // One classic transfer. lat = cycles from the sampling edge to ack/err
    // (-1 on timeout); quiet = dat_r/ack/err were 0 outside the response cycle.
    task automatic xfer(input int d, input bit w, input logic [29:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input bit scramble,
                        output logic [31:0] rd, output int lat, output bit got_ack,
                        output bit got_err, output bit quiet);
        logic ta, te;
        logic [31:0] tr;
        bit done;
        rd = '0; lat = -1; got_ack = 0; got_err = 0; quiet = 1; done = 0;
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_w[d] = wd;
        for (int i = 1; i <= 20 && !done; i++) begin
            @(negedge clk);
            sample(d, ta, te, tr);
            if (ta === 1'b1 || te === 1'b1) begin
                lat = i; rd = tr; got_ack = (ta === 1'b1); got_err = (te === 1'b1);
                done = 1; cyc[d] = 1'b0; stb[d] = 1'b0;
            end else begin
                if (tr !== 32'd0) quiet = 0;
                if (scramble && i == 1) begin
                    stb[d] = 1'($urandom); we[d] = 1'($urandom); adr[d] = 30'($urandom);
                    sel[d] = 4'($urandom); dat_w[d] = $urandom;
                end
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(negedge clk);
        sample(d, ta, te, tr);
        if (ta !== 1'b0 || te !== 1'b0 || tr !== 32'd0) quiet = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack0 got %b want 0", ack0); end
        n_checks++; if (ack3 !== 1'b0) begin n_fail++; $display("FAIL reset_ack3 got %b want 0", ack3); end
        n_checks++; if (dat_r0 !== 32'd0) begin n_fail++; $display("FAIL reset_dat0 got %h want 0", dat_r0); end
        n_checks++; if (dat_r3 !== 32'd0) begin n_fail++; $display("FAIL reset_dat3 got %h want 0", dat_r3); end
        n_checks++; if (err0 !== 1'b0 || err3 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", err0, err3); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] rd; int lat; bit ga, ge, q;
        xfer(0, 1, 30'h5, 4'hF, 32'hDEADBEEF, 0, rd, lat, ga, ge, q);
        n_checks++; if (lat !== 1 || !ga || ge) begin n_fail++; $display("FAIL ws0_write_ack lat %0d ack %0d err %0d want 1 1 0", lat, ga, ge); end
        n_checks++; if (!q) begin n_fail++; $display("FAIL ws0_write_quiet got 0 want 1"); end
        xfer(0, 0, 30'h5, 4'h0, 32'h0, 0, rd, lat, ga, ge, q);
        n_checks++; if (rd !== 32'hDEADBEEF || lat !== 1) begin n_fail++; $display("FAIL ws0_read got %h lat %0d want deadbeef lat 1", rd, lat); end
        xfer(0, 1, 30'h5, 4'b0010, 32'h00005500, 0, rd, lat, ga, ge, q);
        xfer(0, 0, 30'h5, 4'h0, 32'h0, 0, rd, lat, ga, ge, q);
        n_checks++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL byte_sel got %h want dead55ef", rd); end
        xfer(0, 1, 30'h5, 4'b0000, 32'h12345678, 0, rd, lat, ga, ge, q);
        n_checks++; if (lat !== 1 || !ga) begin n_fail++; $display("FAIL sel0_ack lat %0d ack %0d want 1 1", lat, ga); end
        xfer(0, 0, 30'h5, 4'h0, 32'h0, 0, rd, lat, ga, ge, q);
        n_checks++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sel0_nowrite got %h want dead55ef", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; int lat; bit ga, ge, q;
        xfer(1, 1, 30'h33, 4'hF, 32'hA5A50F0F, 1, rd, lat, ga, ge, q);
        n_checks++; if (lat !== 4 || !ga || !q) begin n_fail++; $display("FAIL ws3_write lat %0d ack %0d quiet %0d want 4 1 1", lat, ga, q); end
        xfer(1, 0, 30'h33, 4'h0, 32'h0, 1, rd, lat, ga, ge, q);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ws3_read_lat got %0d want 4", lat); end
        n_checks++; if (rd !== 32'hA5A50F0F) begin n_fail++; $display("FAIL ws3_read_data got %h want a5a50f0f", rd); end
        n_checks++; if (!q) begin n_fail++; $display("FAIL ws3_read_quiet got 0 want 1"); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; bit ga, ge, q, seen;
        xfer(1, 1, 30'h9, 4'hF, 32'h0BADCAFE, 0, rd, lat, ga, ge, q);
        seen = 0;
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 30'h9; sel[1] = 4'hF; dat_w[1] = 32'hFFFFFFFF;
        @(negedge clk); if (ack3 || err3) seen = 1;
        @(negedge clk); if (ack3 || err3) seen = 1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (6) begin @(negedge clk); if (ack3 !== 1'b0 || err3 !== 1'b0) seen = 1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL abort_noack got ack want none"); end
        xfer(1, 0, 30'h9, 4'h0, 32'h0, 0, rd, lat, ga, ge, q);
        n_checks++; if (rd !== 32'h0BADCAFE || lat !== 4) begin n_fail++; $display("FAIL abort_mem got %h lat %0d want 0badcafe lat 4", rd, lat); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; int lat; bit ga, ge, q, seen;
        xfer(1, 1, 30'h7, 4'hF, 32'h11223344, 0, rd, lat, ga, ge, q);
        seen = 0;
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 30'h7; sel[1] = 4'hF; dat_w[1] = 32'hFFFFFFFF;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; stb[1] = 1'b0;
        if (ack3 !== 1'b0 || dat_r3 !== 32'd0) seen = 1;
        repeat (6) begin @(negedge clk); if (ack3 !== 1'b0 || err3 !== 1'b0) seen = 1; end
        cyc[1] = 1'b0;
        n_checks++; if (seen) begin n_fail++; $display("FAIL rst_wait_noack got ack want none"); end
        xfer(1, 0, 30'h7, 4'h0, 32'h0, 0, rd, lat, ga, ge, q);
        n_checks++; if (rd !== 32'h11223344 || lat !== 4 || !ga) begin n_fail++; $display("FAIL rst_wait_next got %h lat %0d want 11223344 lat 4", rd, lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; bit ga, ge, q;
        logic a1, a2, a3;
        logic [31:0] r1, r3;
        xfer(0, 1, 30'h20, 4'hF, 32'h01020304, 0, rd, lat, ga, ge, q);
        xfer(0, 1, 30'h21, 4'hF, 32'h05060708, 0, rd, lat, ga, ge, q);
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 30'h20; sel[0] = 4'h0;
        @(negedge clk); a1 = ack0; r1 = dat_r0; adr[0] = 30'h21;
        @(negedge clk); a2 = ack0;
        @(negedge clk); a3 = ack0; r3 = dat_r0; cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        n_checks++; if (a1 !== 1'b1 || r1 !== 32'h01020304) begin n_fail++; $display("FAIL b2b_first ack %b data %h want 1 01020304", a1, r1); end
        n_checks++; if (a2 !== 1'b0) begin n_fail++; $display("FAIL b2b_gap ack %b want 0", a2); end
        n_checks++; if (a3 !== 1'b1 || r3 !== 32'h05060708) begin n_fail++; $display("FAIL b2b_second ack %b data %h want 1 05060708", a3, r3); end
    endtask

    task automatic test_stb_ignored();
        bit seen;
        seen = 0;
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b0; we[0] = 1'b1; adr[0] = 30'h5; sel[0] = 4'hF; dat_w[0] = 32'h0;
        repeat (5) begin @(negedge clk); if (ack0 !== 1'b0 || err0 !== 1'b0) seen = 1; end
        cyc[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk); if (ack0 !== 1'b0) seen = 1;
        n_checks++; if (seen) begin n_fail++; $display("FAIL stb_low_ignored got ack want none"); end
    endtask

    task automatic test_high_addr();
        logic [31:0] rd; int lat; bit ga, ge, q;
        xfer(0, 1, 30'h0, 4'hF, 32'hCAFEF00D, 0, rd, lat, ga, ge, q);
`ifdef WB_ERR_EN
        xfer(0, 1, 30'h400, 4'hF, 32'hFFFFFFFF, 0, rd, lat, ga, ge, q);
        n_checks++; if (!ge || ga || lat !== 1) begin n_fail++; $display("FAIL err_resp err %0d ack %0d lat %0d want 1 0 1", ge, ga, lat); end
        n_checks++; if (rd !== 32'd0 || !q) begin n_fail++; $display("FAIL err_dat got %h quiet %0d want 0 1", rd, q); end
        xfer(0, 0, 30'h0, 4'h0, 32'h0, 0, rd, lat, ga, ge, q);
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_nowrite got %h want cafef00d", rd); end
`else
        xfer(0, 1, 30'h400, 4'hF, 32'h12345678, 0, rd, lat, ga, ge, q);
        n_checks++; if (!ga || ge || lat !== 1) begin n_fail++; $display("FAIL alias_ack ack %0d err %0d lat %0d want 1 0 1", ga, ge, lat); end
        xfer(0, 0, 30'h0, 4'h0, 32'h0, 0, rd, lat, ga, ge, q);
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL alias_data got %h want 12345678", rd); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, wd; int lat, d, idx, want_lat; bit ga, ge, q, w, scr;
        logic [3:0] s;
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                mdl[dd][i] = wd;
                xfer(dd, 1, 30'h100 + 30'(i), 4'hF, wd, 0, rd, lat, ga, ge, q);
            end
        end
        for (int n = 0; n < 60; n++) begin
            d = int'($urandom_range(1, 0)); idx = int'($urandom_range(15, 0));
            w = 1'($urandom); s = 4'($urandom); wd = $urandom; scr = 1'($urandom);
            want_lat = (d == 0) ? 1 : 4;
            xfer(d, w, 30'h100 + 30'(idx), s, wd, scr, rd, lat, ga, ge, q);
            n_checks++; if (lat !== want_lat || !ga || ge) begin n_fail++; $display("FAIL rand_resp op %0d lat %0d ack %0d err %0d want %0d 1 0", n, lat, ga, ge, want_lat); end
            n_checks++; if (!q) begin n_fail++; $display("FAIL rand_quiet op %0d got 0 want 1", n); end
            if (w) begin
                for (int b = 0; b < 4; b++) if (s[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                n_checks++; if (rd !== mdl[d][idx]) begin n_fail++; $display("FAIL rand_read op %0d dut %0d idx %0d got %h want %h", n, d, idx, rd, mdl[d][idx]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cyc = '0; stb = '0; we = '0;
        for (int i = 0; i < 2; i++) begin adr[i] = '0; sel[i] = '0; dat_w[i] = '0; end
        test_reset();
        test_basic();
        test_wait_states();
        test_abort();
        test_reset_in_wait();
        test_back_to_back();
        test_stb_ignored();
        test_high_addr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
